// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - cache refill request/return and AXI AR/R signal bundle
interface axi_rd_arbiter_if;
  logic        i_rd_req;
  logic [2:0]  i_rd_type;
  logic [31:0] i_rd_addr;
  logic        i_rd_rdy;
  logic        i_ret_valid;
  logic        i_ret_last;
  logic [31:0] i_ret_data;

  logic        d_rd_req;
  logic [2:0]  d_rd_type;
  logic [31:0] d_rd_addr;
  logic        d_rd_rdy;
  logic        d_ret_valid;
  logic        d_ret_last;
  logic [31:0] d_ret_data;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  i_rd_req, i_rd_type, i_rd_addr,
    output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    input  d_rd_req, d_rd_type, d_rd_addr,
    output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output i_rd_req, i_rd_type, i_rd_addr,
    input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
    output d_rd_req, d_rd_type, d_rd_addr,
    input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - round-robin icache/dcache refill arbiter onto one AXI read port
module axi_rd_arbiter #(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1
) (
  input logic             clk,
  input logic             reset,
  axi_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_AR = 2'd1, WAIT_R = 2'd2} req_state_t;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  req_state_t  state_i, state_i_nxt, state_d, state_d_nxt;
  logic        last_grant, last_grant_nxt;
  logic        ar_valid_q, ar_valid_nxt;
  logic [3:0]  ar_id_q, ar_id_nxt;
  logic [31:0] ar_addr_q, ar_addr_nxt;
  logic [7:0]  ar_len_q, ar_len_nxt;
  logic [2:0]  ar_size_q, ar_size_nxt;

  logic elig_i, elig_d, grant_i, grant_d, ar_fire, beat_i, beat_d;
  logic unused_rresp;

  function automatic logic [31:0] xlate_addr(input logic [2:0] t, input logic [31:0] a);
    return (t == 3'b100) ? {a[31:4], 4'h0} : a;
  endfunction

  function automatic logic [7:0] xlate_len(input logic [2:0] t);
    return (t == 3'b100) ? 8'd3 : 8'd0;
  endfunction

  function automatic logic [2:0] xlate_size(input logic [2:0] t);
    return (t == 3'b100) ? 3'd2 : {1'b0, t[1:0]};
  endfunction

  // A single AR slot: nobody is accepted while it is occupied.
  assign elig_i  = bus.i_rd_req && (state_i == IDLE) && !ar_valid_q;
  assign elig_d  = bus.d_rd_req && (state_d == IDLE) && !ar_valid_q;
  assign grant_i = elig_i && (!elig_d || (last_grant == GRANT_D));
  assign grant_d = elig_d && (!elig_i || (last_grant == GRANT_I));
  assign ar_fire = ar_valid_q && bus.arready;
  assign beat_i  = bus.rvalid && (bus.rid == ID_I) && (state_i == WAIT_R);
  assign beat_d  = bus.rvalid && (bus.rid == ID_D) && (state_d == WAIT_R);

  always_comb begin
    state_i_nxt    = state_i;
    state_d_nxt    = state_d;
    last_grant_nxt = last_grant;
    ar_valid_nxt   = ar_valid_q;
    ar_id_nxt      = ar_id_q;
    ar_addr_nxt    = ar_addr_q;
    ar_len_nxt     = ar_len_q;
    ar_size_nxt    = ar_size_q;

    case (state_i)
      IDLE:    if (grant_i) state_i_nxt = WAIT_AR;
      WAIT_AR: if (ar_fire && (ar_id_q == ID_I)) state_i_nxt = WAIT_R;
      WAIT_R:  if (beat_i && bus.rlast) state_i_nxt = IDLE;
      default: state_i_nxt = IDLE;
    endcase

    case (state_d)
      IDLE:    if (grant_d) state_d_nxt = WAIT_AR;
      WAIT_AR: if (ar_fire && (ar_id_q == ID_D)) state_d_nxt = WAIT_R;
      WAIT_R:  if (beat_d && bus.rlast) state_d_nxt = IDLE;
      default: state_d_nxt = IDLE;
    endcase

    if (ar_fire) ar_valid_nxt = 1'b0;

    // Grants only happen with the AR slot empty, so they never collide with ar_fire.
    if (grant_i) begin
      ar_valid_nxt   = 1'b1;
      ar_id_nxt      = ID_I;
      ar_addr_nxt    = xlate_addr(bus.i_rd_type, bus.i_rd_addr);
      ar_len_nxt     = xlate_len(bus.i_rd_type);
      ar_size_nxt    = xlate_size(bus.i_rd_type);
      last_grant_nxt = GRANT_I;
    end else if (grant_d) begin
      ar_valid_nxt   = 1'b1;
      ar_id_nxt      = ID_D;
      ar_addr_nxt    = xlate_addr(bus.d_rd_type, bus.d_rd_addr);
      ar_len_nxt     = xlate_len(bus.d_rd_type);
      ar_size_nxt    = xlate_size(bus.d_rd_type);
      last_grant_nxt = GRANT_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_i    <= IDLE;
      state_d    <= IDLE;
      last_grant <= GRANT_D;
      ar_valid_q <= 1'b0;
      ar_id_q    <= 4'd0;
      ar_addr_q  <= 32'd0;
      ar_len_q   <= 8'd0;
      ar_size_q  <= 3'd0;
    end else begin
      state_i    <= state_i_nxt;
      state_d    <= state_d_nxt;
      last_grant <= last_grant_nxt;
      ar_valid_q <= ar_valid_nxt;
      ar_id_q    <= ar_id_nxt;
      ar_addr_q  <= ar_addr_nxt;
      ar_len_q   <= ar_len_nxt;
      ar_size_q  <= ar_size_nxt;
    end
  end

  assign bus.i_rd_rdy    = grant_i && !reset;
  assign bus.d_rd_rdy    = grant_d && !reset;
  assign bus.i_ret_valid = beat_i && !reset;
  assign bus.d_ret_valid = beat_d && !reset;
  assign bus.i_ret_data  = bus.rdata;
  assign bus.d_ret_data  = bus.rdata;
  assign bus.i_ret_last  = bus.rlast;
  assign bus.d_ret_last  = bus.rlast;

  assign bus.arvalid = ar_valid_q;
  assign bus.arid    = ar_id_q;
  assign bus.araddr  = ar_addr_q;
  assign bus.arlen   = ar_len_q;
  assign bus.arsize  = ar_size_q;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.rready  = 1'b1;

  assign unused_rresp = ^bus.rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed and randomized bench for axi_rd_arbiter
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [2:0] type_tab [4] = '{3'b000, 3'b001, 3'b010, 3'b100};

  always #5 clk = ~clk;

  axi_rd_arbiter_if bus();

  axi_rd_arbiter #(.ID_I(4'd0), .ID_D(4'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] exp_addr(input logic [2:0] t, input logic [31:0] a);
    return (t == 3'b100) ? (a & 32'hFFFF_FFF0) : a;
  endfunction

  function automatic logic [7:0] exp_len(input logic [2:0] t);
    return (t == 3'b100) ? 8'd3 : 8'd0;
  endfunction

  function automatic logic [2:0] exp_size(input logic [2:0] t);
    return (t == 3'b100) ? 3'd2 : (t & 3'd3);
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.i_rd_req = 0; bus.i_rd_type = 0; bus.i_rd_addr = 0;
    bus.d_rd_req = 0; bus.d_rd_type = 0; bus.d_rd_addr = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
  endtask

  task automatic pulse_reset();
    cyc(); idle_inputs(); reset = 1;
    cyc(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    bus.i_rd_req = 1; bus.d_rd_req = 1; bus.rvalid = 1; bus.rid = 0; bus.rlast = 0;
    repeat (2) cyc();
    #1;
    checks++; if (bus.i_rd_rdy !== 1'b0) begin errors++; $display("FAIL reset_i_rdy got=%0b exp=0", bus.i_rd_rdy); end
    checks++; if (bus.d_rd_rdy !== 1'b0) begin errors++; $display("FAIL reset_d_rdy got=%0b exp=0", bus.d_rd_rdy); end
    checks++; if ({bus.i_ret_valid, bus.d_ret_valid} !== 2'b00) begin errors++; $display("FAIL reset_ret_valid got=%0b%0b exp=00", bus.i_ret_valid, bus.d_ret_valid); end
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%0b exp=0", bus.arvalid); end
    checks++; if ({bus.arid, bus.araddr, bus.arlen, bus.arsize} !== 47'd0) begin errors++; $display("FAIL reset_ar_fields got=%0h/%0h/%0h/%0h exp=0", bus.arid, bus.araddr, bus.arlen, bus.arsize); end
    checks++; if ({bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.rready} !== 12'b01_00_0000_000_1) begin errors++; $display("FAIL const_outputs got=%0b exp=010000000001", {bus.arburst, bus.arlock, bus.arcache, bus.arprot, bus.rready}); end
    cyc(); idle_inputs(); reset = 0;
  endtask

  task automatic test_icache_line();
    logic [31:0] d;
    cyc();
    bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h1C00_0014; bus.arready = 1;
    #1;
    checks++; if (bus.i_rd_rdy !== 1'b1) begin errors++; $display("FAIL line_i_rdy got=%0b exp=1", bus.i_rd_rdy); end
    cyc(); bus.i_rd_req = 0; #1;
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL line_arvalid got=%0b exp=1", bus.arvalid); end
    checks++; if ({bus.arid, bus.araddr, bus.arlen, bus.arsize} !== {4'd0, 32'h1C00_0010, 8'd3, 3'd2}) begin errors++; $display("FAIL line_ar_fields got=%0h/%0h/%0h/%0h exp=0/1c000010/3/2", bus.arid, bus.araddr, bus.arlen, bus.arsize); end
    cyc(); bus.arready = 0; #1;
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL line_arvalid_drop got=%0b exp=0", bus.arvalid); end
    for (int b = 0; b < 4; b++) begin
      cyc();
      d = $urandom;
      bus.rvalid = 1; bus.rid = 0; bus.rdata = d; bus.rlast = (b == 3);
      #1;
      checks++; if ({bus.i_ret_valid, bus.d_ret_valid, bus.i_ret_last} !== {1'b1, 1'b0, (b == 3)}) begin errors++; $display("FAIL line_beat%0d v/dv/last got=%0b%0b%0b exp=10%0b", b, bus.i_ret_valid, bus.d_ret_valid, bus.i_ret_last, (b == 3)); end
      checks++; if (bus.i_ret_data !== d) begin errors++; $display("FAIL line_beat%0d_data got=%0h exp=%0h", b, bus.i_ret_data, d); end
    end
    cyc(); idle_inputs();
  endtask

  task automatic single_beat(input logic [3:0] id, input bit to_i);
    cyc(); bus.rvalid = 1; bus.rid = id; bus.rlast = 1; bus.rdata = $urandom; #1;
    checks++; if ((to_i ? bus.i_ret_valid : bus.d_ret_valid) !== 1'b1) begin errors++; $display("FAIL single_beat id=%0d got=0 exp=1", id); end
    cyc(); bus.rvalid = 0; bus.rlast = 0;
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    bus.i_rd_req = 1; bus.i_rd_type = 3'b010; bus.i_rd_addr = 32'h100;
    bus.d_rd_req = 1; bus.d_rd_type = 3'b010; bus.d_rd_addr = 32'h200; bus.arready = 1;
    #1;
    checks++; if ({bus.i_rd_rdy, bus.d_rd_rdy} !== 2'b10) begin errors++; $display("FAIL tie1 rdy i/d got=%0b%0b exp=10", bus.i_rd_rdy, bus.d_rd_rdy); end
    cyc(); bus.i_rd_req = 0; #1;
    checks++; if ({bus.arvalid, bus.arid, bus.d_rd_rdy} !== {1'b1, 4'd0, 1'b0}) begin errors++; $display("FAIL tie1_ar_i got v=%0b id=%0d drdy=%0b exp v=1 id=0 drdy=0", bus.arvalid, bus.arid, bus.d_rd_rdy); end
    cyc(); #1;
    checks++; if ({bus.arvalid, bus.d_rd_rdy} !== 2'b01) begin errors++; $display("FAIL tie1_d_late got v=%0b drdy=%0b exp v=0 drdy=1", bus.arvalid, bus.d_rd_rdy); end
    cyc(); bus.d_rd_req = 0; #1;
    checks++; if ({bus.arvalid, bus.arid, bus.araddr} !== {1'b1, 4'd1, 32'h200}) begin errors++; $display("FAIL tie1_ar_d got v=%0b id=%0d addr=%0h exp v=1 id=1 addr=200", bus.arvalid, bus.arid, bus.araddr); end
    single_beat(4'd0, 1'b1);
    single_beat(4'd1, 1'b0);
    bus.i_rd_req = 1; bus.d_rd_req = 1; #1;
    checks++; if ({bus.i_rd_rdy, bus.d_rd_rdy} !== 2'b10) begin errors++; $display("FAIL tie2 rdy i/d got=%0b%0b exp=10", bus.i_rd_rdy, bus.d_rd_rdy); end
    cyc(); bus.i_rd_req = 0; bus.d_rd_req = 0;
    cyc();
    single_beat(4'd0, 1'b1);
    bus.i_rd_req = 1; bus.d_rd_req = 1; #1;
    checks++; if ({bus.i_rd_rdy, bus.d_rd_rdy} !== 2'b01) begin errors++; $display("FAIL tie3 rdy i/d got=%0b%0b exp=01", bus.i_rd_rdy, bus.d_rd_rdy); end
    cyc(); bus.i_rd_req = 0; bus.d_rd_req = 0; #1;
    checks++; if (bus.arid !== 4'd1) begin errors++; $display("FAIL tie3_arid got=%0d exp=1", bus.arid); end
    cyc();
    single_beat(4'd1, 1'b0);
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    cyc(); bus.d_rd_req = 1; bus.d_rd_type = 3'b010; bus.d_rd_addr = 32'h800; bus.arready = 0; #1;
    checks++; if (bus.d_rd_rdy !== 1'b1) begin errors++; $display("FAIL bp_d_rdy got=%0b exp=1", bus.d_rd_rdy); end
    for (int k = 0; k < 5; k++) begin
      cyc(); bus.d_rd_req = 0; #1;
      checks++; if ({bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize} !== {1'b1, 4'd1, 32'h800, 8'd0, 3'd2}) begin errors++; $display("FAIL bp_hold%0d got v=%0b id=%0d a=%0h l=%0d s=%0d exp v=1 id=1 a=800 l=0 s=2", k, bus.arvalid, bus.arid, bus.araddr, bus.arlen, bus.arsize); end
    end
    cyc(); bus.arready = 1; #1;
    checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL bp_hs_valid got=%0b exp=1", bus.arvalid); end
    cyc(); bus.arready = 0; #1;
    checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL bp_drop got=%0b exp=0", bus.arvalid); end
    d = $urandom;
    bus.rvalid = 1; bus.rid = 1; bus.rlast = 1; bus.rdata = d; #1;
    checks++; if ({bus.d_ret_valid, bus.d_ret_last, bus.i_ret_valid} !== 3'b110) begin errors++; $display("FAIL bp_beat got dv=%0b dl=%0b iv=%0b exp 1 1 0", bus.d_ret_valid, bus.d_ret_last, bus.i_ret_valid); end
    checks++; if (bus.d_ret_data !== d) begin errors++; $display("FAIL bp_data got=%0h exp=%0h", bus.d_ret_data, d); end
    cyc(); idle_inputs();
  endtask

  task automatic test_interleave();
    int order [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int seen [2];
    logic [31:0] d;
    seen[0] = 0; seen[1] = 0;
    cyc(); bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h3000; bus.arready = 1; #1;
    checks++; if (bus.i_rd_rdy !== 1'b1) begin errors++; $display("FAIL il_i_rdy got=%0b exp=1", bus.i_rd_rdy); end
    cyc(); bus.i_rd_req = 0; bus.d_rd_req = 1; bus.d_rd_type = 3'b100; bus.d_rd_addr = 32'h4008;
    cyc(); #1;
    checks++; if (bus.d_rd_rdy !== 1'b1) begin errors++; $display("FAIL il_d_rdy got=%0b exp=1", bus.d_rd_rdy); end
    cyc(); bus.d_rd_req = 0; #1;
    checks++; if ({bus.arid, bus.araddr} !== {4'd1, 32'h4000}) begin errors++; $display("FAIL il_ar_d got id=%0d a=%0h exp id=1 a=4000", bus.arid, bus.araddr); end
    cyc(); bus.arready = 0;
    for (int b = 0; b < 8; b++) begin
      if (b > 0) cyc();
      d = $urandom;
      bus.rvalid = 1; bus.rid = order[b][3:0]; bus.rdata = d; bus.rlast = (seen[order[b]] == 3);
      #1;
      if (bus.i_ret_valid) seen[0]++;
      if (bus.d_ret_valid) seen[1]++;
      checks++; if ({bus.i_ret_valid, bus.d_ret_valid} !== ((order[b] == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL il_route%0d got iv/dv=%0b%0b rid=%0d", b, bus.i_ret_valid, bus.d_ret_valid, order[b]); end
      checks++; if (((order[b] == 0) ? bus.i_ret_data : bus.d_ret_data) !== d) begin errors++; $display("FAIL il_data%0d got=%0h exp=%0h", b, (order[b] == 0) ? bus.i_ret_data : bus.d_ret_data, d); end
    end
    checks++; if (seen[0] !== 4 || seen[1] !== 4) begin errors++; $display("FAIL il_count got i=%0d d=%0d exp 4/4", seen[0], seen[1]); end
    cyc(); idle_inputs();
  endtask

  task automatic test_stray();
    logic [3:0] ids [3] = '{4'd2, 4'd1, 4'd0};
    for (int k = 0; k < 3; k++) begin
      cyc(); bus.rvalid = 1; bus.rid = ids[k]; bus.rlast = 1; bus.rdata = $urandom; #1;
      checks++; if ({bus.i_ret_valid, bus.d_ret_valid, bus.rready} !== 3'b001) begin errors++; $display("FAIL stray rid=%0d got iv/dv/rr=%0b%0b%0b exp=001", ids[k], bus.i_ret_valid, bus.d_ret_valid, bus.rready); end
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_reset_mid();
    cyc(); bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h40; bus.arready = 1;
    cyc(); bus.i_rd_req = 0;
    cyc(); bus.arready = 0;
    for (int b = 0; b < 2; b++) begin
      bus.rvalid = 1; bus.rid = 0; bus.rlast = 0; #1;
      checks++; if (bus.i_ret_valid !== 1'b1) begin errors++; $display("FAIL rm_beat%0d got=%0b exp=1", b, bus.i_ret_valid); end
      cyc();
    end
    bus.rvalid = 0; reset = 1;
    cyc(); reset = 0;
    bus.rvalid = 1; bus.rid = 0; bus.rlast = 0;
    bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h80; bus.arready = 1; #1;
    checks++; if ({bus.arvalid, bus.i_ret_valid, bus.i_rd_rdy} !== 3'b001) begin errors++; $display("FAIL rm_after got av/iv/irdy=%0b%0b%0b exp=001", bus.arvalid, bus.i_ret_valid, bus.i_rd_rdy); end
    cyc(); bus.i_rd_req = 0; #1;
    checks++; if ({bus.arvalid, bus.araddr, bus.i_ret_valid} !== {1'b1, 32'h80, 1'b0}) begin errors++; $display("FAIL rm_new_ar got av=%0b a=%0h iv=%0b exp 1/80/0", bus.arvalid, bus.araddr, bus.i_ret_valid); end
    for (int b = 0; b < 4; b++) begin
      cyc(); bus.arready = 0; bus.rvalid = 1; bus.rid = 0; bus.rlast = (b == 3); #1;
      checks++; if (bus.i_ret_valid !== 1'b1) begin errors++; $display("FAIL rm_refill%0d got=%0b exp=1", b, bus.i_ret_valid); end
    end
    cyc(); idle_inputs();
  endtask

  task automatic test_random();
    bit busy [2];
    bit rph [2];
    int left [2];
    bit ar_pend;
    int ar_own;
    logic [31:0] ar_a;
    logic [7:0]  ar_l;
    logic [2:0]  ar_s;
    int lg;
    bit e_i, e_d, x_i, x_d, xv_i, xv_d;
    int r, s;
    pulse_reset();
    busy = '{0, 0}; rph = '{0, 0}; left = '{0, 0};
    ar_pend = 0; ar_own = 0; ar_a = 0; ar_l = 0; ar_s = 0; lg = 1;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) cyc();
      bus.i_rd_req = $urandom_range(0, 1); bus.i_rd_type = type_tab[$urandom_range(0, 3)]; bus.i_rd_addr = $urandom;
      bus.d_rd_req = $urandom_range(0, 1); bus.d_rd_type = type_tab[$urandom_range(0, 3)]; bus.d_rd_addr = $urandom;
      bus.arready = ($urandom_range(0, 2) != 0);
      bus.rdata = $urandom; bus.rvalid = 0; bus.rlast = 0; bus.rid = 0;
      r = $urandom_range(0, 4);
      if (r == 0) begin
        s = $urandom_range(0, 1);
        bus.rvalid = 1; bus.rlast = $urandom_range(0, 1);
        bus.rid = rph[s] ? 4'($urandom_range(2, 15)) : 4'(s);
      end else if (r <= 2 && (rph[0] || rph[1])) begin
        s = (rph[0] && rph[1]) ? $urandom_range(0, 1) : (rph[0] ? 0 : 1);
        bus.rvalid = 1; bus.rid = 4'(s); bus.rlast = (left[s] == 1);
      end
      #1;
      e_i = bus.i_rd_req && !busy[0] && !ar_pend;
      e_d = bus.d_rd_req && !busy[1] && !ar_pend;
      x_i = e_i && (!e_d || lg == 1);
      x_d = e_d && (!e_i || lg == 0);
      xv_i = bus.rvalid && bus.rid == 4'd0 && rph[0];
      xv_d = bus.rvalid && bus.rid == 4'd1 && rph[1];
      checks++; if ({bus.i_rd_rdy, bus.d_rd_rdy} !== {x_i, x_d}) begin errors++; $display("FAIL rnd%0d_rdy got=%0b%0b exp=%0b%0b", c, bus.i_rd_rdy, bus.d_rd_rdy, x_i, x_d); end
      checks++; if (bus.arvalid !== ar_pend) begin errors++; $display("FAIL rnd%0d_arvalid got=%0b exp=%0b", c, bus.arvalid, ar_pend); end
      if (ar_pend) begin
        checks++; if ({bus.arid, bus.araddr, bus.arlen, bus.arsize} !== {4'(ar_own), ar_a, ar_l, ar_s}) begin errors++; $display("FAIL rnd%0d_ar got %0h/%0h/%0h/%0h exp %0h/%0h/%0h/%0h", c, bus.arid, bus.araddr, bus.arlen, bus.arsize, ar_own, ar_a, ar_l, ar_s); end
      end
      checks++; if ({bus.i_ret_valid, bus.d_ret_valid} !== {xv_i, xv_d}) begin errors++; $display("FAIL rnd%0d_ret got=%0b%0b exp=%0b%0b", c, bus.i_ret_valid, bus.d_ret_valid, xv_i, xv_d); end
      if (xv_i || xv_d) begin
        s = xv_i ? 0 : 1;
        checks++; if ((s == 0 ? {bus.i_ret_data, bus.i_ret_last} : {bus.d_ret_data, bus.d_ret_last}) !== {bus.rdata, (left[s] == 1)}) begin errors++; $display("FAIL rnd%0d_beat side=%0d data/last mismatch to rdata=%0h left=%0d", c, s, bus.rdata, left[s]); end
        left[s]--;
        if (bus.rlast) begin rph[s] = 0; busy[s] = 0; end
      end
      if (ar_pend && bus.arready) begin
        ar_pend = 0; rph[ar_own] = 1; left[ar_own] = int'(ar_l) + 1;
      end
      if (x_i) begin
        busy[0] = 1; ar_pend = 1; ar_own = 0; lg = 0;
        ar_a = exp_addr(bus.i_rd_type, bus.i_rd_addr); ar_l = exp_len(bus.i_rd_type); ar_s = exp_size(bus.i_rd_type);
      end else if (x_d) begin
        busy[1] = 1; ar_pend = 1; ar_own = 1; lg = 1;
        ar_a = exp_addr(bus.d_rd_type, bus.d_rd_addr); ar_l = exp_len(bus.d_rd_type); ar_s = exp_size(bus.d_rd_type);
      end
    end
    cyc(); idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_icache_line();
    test_simultaneous();
    test_backpressure();
    test_interleave();
    test_stray();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
